// File: rtl/y86_pkg.sv
// Shared Y86 definitions for the writeback / register-file slice.
//   - icode constants (HALT=0, NOP=1, ...)
//   - status codes BUB/AOK/HLT/ADR/INS
//   - register IDs RNONE (no register) and RRSP
//   - writeback FSM state enum
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] STAT_BUB = 4'd0;
  localparam logic [3:0] STAT_AOK = 4'd1;
  localparam logic [3:0] STAT_HLT = 4'd2;
  localparam logic [3:0] STAT_ADR = 4'd3;
  localparam logic [3:0] STAT_INS = 4'd4;

  localparam logic [3:0] RNONE = 4'hf;
  localparam logic [3:0] RRSP  = 4'd4;

  typedef enum logic [1:0] {
    FSM_RUN = 2'd0,
    FSM_HLT = 2'd1,
    FSM_ADR = 2'd2,
    FSM_INS = 2'd3
  } wb_state_e;

endpackage

// File: rtl/writeback_regfile_if.sv
// Bundle of memory-stage inputs, decode read ports and writeback outputs
// for writeback_regfile.
//   master : pipeline side (drives M_*, W_stall, W_bubble, srcA/srcB)
//   slave  : writeback_regfile (drives W_*, d_rvalA/B, Stat, halted, retired,
//            state_dbg)
// Handshake: there is no valid/ready pair; every field is sampled on each
// rising clk edge, W_stall holds the W register and W_bubble loads a nop.
interface writeback_regfile_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 64
);
  import y86_pkg::*;

  logic [3:0]        M_icode;
  logic [3:0]        M_stat;
  logic [3:0]        M_dstE;
  logic [3:0]        M_dstM;
  logic [DATA_W-1:0] M_valE;
  logic [DATA_W-1:0] m_valM;
  logic              W_stall;
  logic              W_bubble;
  logic [3:0]        srcA;
  logic [3:0]        srcB;

  logic [DATA_W-1:0] d_rvalA;
  logic [DATA_W-1:0] d_rvalB;
  logic [3:0]        W_icode;
  logic [3:0]        W_stat;
  logic [3:0]        W_dstE;
  logic [3:0]        W_dstM;
  logic [DATA_W-1:0] W_valE;
  logic [DATA_W-1:0] W_valM;
  logic [3:0]        Stat;
  logic              halted;
  logic [CNT_W-1:0]  retired;
  wb_state_e         state_dbg;

  modport master (
    output M_icode, M_stat, M_dstE, M_dstM, M_valE, m_valM,
           W_stall, W_bubble, srcA, srcB,
    input  d_rvalA, d_rvalB, W_icode, W_stat, W_dstE, W_dstM,
           W_valE, W_valM, Stat, halted, retired, state_dbg
  );

  modport slave (
    input  M_icode, M_stat, M_dstE, M_dstM, M_valE, m_valM,
           W_stall, W_bubble, srcA, srcB,
    output d_rvalA, d_rvalB, W_icode, W_stat, W_dstE, W_dstM,
           W_valE, W_valM, Stat, halted, retired, state_dbg
  );
endinterface

// File: rtl/writeback_regfile_regfile_2w2r.sv
// Architectural register file: NREGS x DATA_W, two write ports, two
// asynchronous read ports, synchronous active-high clear.
//   we_e/waddr_e/wdata_e : write port E (ALU result)
//   we_m/waddr_m/wdata_m : write port M (memory data, wins on same address)
//   raddr_a/raddr_b      : read addresses; IDs >= NREGS (incl. RNONE) read 0
//   rdata_a/rdata_b      : read data
module regfile_2w2r #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_e,
  input  logic [3:0]        waddr_e,
  input  logic [DATA_W-1:0] wdata_e,
  input  logic              we_m,
  input  logic [3:0]        waddr_m,
  input  logic [DATA_W-1:0] wdata_m,
  input  logic [3:0]        raddr_a,
  input  logic [3:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam logic [3:0] NREGS_ID = 4'(NREGS);

  logic [DATA_W-1:0] regs [NREGS];

  // Port M is written last so it overrides port E on a shared address
  // (popq %rsp loads the popped value, not the incremented pointer).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (we_e && (waddr_e < NREGS_ID)) regs[waddr_e] <= wdata_e;
      if (we_m && (waddr_m < NREGS_ID)) regs[waddr_m] <= wdata_m;
    end
  end

  assign rdata_a = (raddr_a < NREGS_ID) ? regs[raddr_a] : '0;
  assign rdata_b = (raddr_b < NREGS_ID) ? regs[raddr_b] : '0;

endmodule

// File: rtl/writeback_regfile.sv
// Y86 M->W pipeline register, register-file write port and CPU status unit.
// Latches memory-stage results into W_*, commits W_valE/W_valM to the
// register file, serves decode's srcA/srcB read ports, tracks halt/fault
// status and counts retired instructions.
//   clk, reset : clock, synchronous active-high reset
//   bus        : writeback_regfile_if.slave (M_* inputs, W_stall/W_bubble,
//                srcA/srcB, d_rvalA/B, W_* outputs, Stat, halted, retired,
//                state_dbg)
// Configuration macro WB_BYPASS_EN: when defined, the read ports return the
// value being committed this cycle (W_dstM before W_dstE); otherwise they
// return register-array contents only.
module writeback_regfile
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15,
  parameter int CNT_W  = 64
) (
  input  logic clk,
  input  logic reset,
  writeback_regfile_if.slave bus
);

  localparam logic [3:0] NREGS_ID = 4'(NREGS);

  logic [3:0]        w_icode, w_stat, w_dste, w_dstm;
  logic [DATA_W-1:0] w_vale, w_valm;
  // Set once the instruction held in W has committed; cleared whenever W
  // reloads, so a stalled instruction commits and counts exactly once.
  logic              w_done;

  wb_state_e         state;
  logic [3:0]        stat_q;
  logic              halted_q;
  logic [CNT_W-1:0]  retired_q;

  logic              commit_en, we_e, we_m;
  logic [DATA_W-1:0] rf_a, rf_b, rval_a, rval_b;

  assign commit_en = (state == FSM_RUN) && (w_stat == STAT_AOK) && !w_done;
  assign we_e      = commit_en && (w_dste != RNONE);
  assign we_m      = commit_en && (w_dstm != RNONE);

  // W pipeline register: stall beats bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_icode <= I_NOP;
      w_stat  <= STAT_BUB;
      w_dste  <= RNONE;
      w_dstm  <= RNONE;
      w_vale  <= '0;
      w_valm  <= '0;
      w_done  <= 1'b0;
    end else if (!bus.W_stall) begin
      if (bus.W_bubble) begin
        w_icode <= I_NOP;
        w_stat  <= STAT_BUB;
        w_dste  <= RNONE;
        w_dstm  <= RNONE;
        w_vale  <= '0;
        w_valm  <= '0;
      end else begin
        w_icode <= bus.M_icode;
        w_stat  <= bus.M_stat;
        w_dste  <= bus.M_dstE;
        w_dstm  <= bus.M_dstM;
        w_vale  <= bus.M_valE;
        w_valm  <= bus.m_valM;
      end
      w_done <= 1'b0;
    end else if (commit_en) begin
      w_done <= 1'b1;
    end
  end

  // Status FSM (sticky until reset) and saturating retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FSM_RUN;
      stat_q    <= STAT_AOK;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      if (commit_en && (retired_q != '1)) retired_q <= retired_q + CNT_W'(1);
      if (state == FSM_RUN) begin
        case (w_stat)
          STAT_HLT: begin
            state    <= FSM_HLT;
            stat_q   <= STAT_HLT;
            halted_q <= 1'b1;
          end
          STAT_ADR: begin
            state    <= FSM_ADR;
            stat_q   <= STAT_ADR;
            halted_q <= 1'b1;
          end
          STAT_INS: begin
            state    <= FSM_INS;
            stat_q   <= STAT_INS;
            halted_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  regfile_2w2r #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we_e    (we_e),
    .waddr_e (w_dste),
    .wdata_e (w_vale),
    .we_m    (we_m),
    .waddr_m (w_dstm),
    .wdata_m (w_valm),
    .raddr_a (bus.srcA),
    .raddr_b (bus.srcB),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

`ifdef WB_BYPASS_EN
  // Write-through: a register being committed this cycle is visible at once.
  always_comb begin
    rval_a = rf_a;
    if (we_m && (w_dstm < NREGS_ID) && (bus.srcA == w_dstm))      rval_a = w_valm;
    else if (we_e && (w_dste < NREGS_ID) && (bus.srcA == w_dste)) rval_a = w_vale;
  end

  always_comb begin
    rval_b = rf_b;
    if (we_m && (w_dstm < NREGS_ID) && (bus.srcB == w_dstm))      rval_b = w_valm;
    else if (we_e && (w_dste < NREGS_ID) && (bus.srcB == w_dste)) rval_b = w_vale;
  end
`else
  // Array contents only; decode forwarding resolves W-stage hazards.
  localparam logic [3:0] UNUSED_NREGS_ID = NREGS_ID;
  always_comb begin
    rval_a = rf_a;
    rval_b = rf_b;
  end
`endif

  assign bus.d_rvalA   = rval_a;
  assign bus.d_rvalB   = rval_b;
  assign bus.W_icode   = w_icode;
  assign bus.W_stat    = w_stat;
  assign bus.W_dstE    = w_dste;
  assign bus.W_dstM    = w_dstm;
  assign bus.W_valE    = w_vale;
  assign bus.W_valM    = w_valm;
  assign bus.Stat      = stat_q;
  assign bus.halted    = halted_q;
  assign bus.retired   = retired_q;
  assign bus.state_dbg = state;

endmodule
